// File: rtl/da_stream_driver_pkg.sv
// Shared types and constants for the DAC stream driver.
package da_stream_driver_pkg;

   localparam int unsigned DATA_W           = 14;
   localparam logic [13:0] MIDSCALE         = 14'h2000;
   // 108 MHz / (2*3) = 18 MHz DA_Clock
   localparam int unsigned DEF_CLK_HALF_DIV = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } state_e;

endpackage

// File: rtl/da_stream_driver_fifo.sv
// Synchronous single-clock sample FIFO with registered level and not-full.
module da_sample_fifo #(
   parameter int unsigned DATA_W = da_stream_driver_pkg::DATA_W,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [DATA_W-1:0]          push_data_i,
   input  logic                       pop_i,
   output logic [DATA_W-1:0]          head_c_o,
   output logic                       empty_c_o,
   output logic                       ready_o,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [LW-1:0]     level_q;
   logic [LW-1:0]     level_d;
   logic              ready_q;

   always_comb begin
      level_d = level_q;
      if (push_i && !pop_i) begin
         level_d = level_q + LW'(1);
      end else if (pop_i && !push_i) begin
         level_d = level_q - LW'(1);
      end
   end

   // Storage carries no reset; only pointers and level define contents.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         if (push_i) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         level_q <= level_d;
         ready_q <= (level_d != LW'(DEPTH));
      end
   end

   assign head_c_o  = mem_q[rd_ptr_q];
   assign empty_c_o = (level_q == '0);
   assign ready_o   = ready_q;
   assign level_o   = level_q;

endmodule

// File: rtl/da_stream_driver.sv
// Streams FIFO samples to a parallel DAC, one per DA_Clock, launched on its falling edge.
module da_stream_driver
   import da_stream_driver_pkg::*;
#(
   parameter int unsigned DATA_W       = da_stream_driver_pkg::DATA_W,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned CLK_HALF_DIV = da_stream_driver_pkg::DEF_CLK_HALF_DIV,
   parameter int unsigned PRIME_LEVEL  = 8,
   parameter int unsigned TWOS_COMP    = 1
) (
   input  logic                          Sys_Clock,
   input  logic                          Reset,
   input  logic                          Enable,
   input  logic [DATA_W-1:0]             In_Data,
   input  logic                          In_Valid,
   output logic                          In_Ready,
   output logic [DATA_W-1:0]             DA_Data,
   output logic                          DA_Clock,
   output logic                          Busy,
   output logic [$clog2(FIFO_DEPTH):0]   Fifo_Level,
   output logic [15:0]                   Underflow_Count
);

   localparam int unsigned LW    = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned DIV_W = 16;
   // Midscale doubles as the MSB-flip mask for two's complement -> offset binary.
   localparam logic [DATA_W-1:0] MID =
      (TWOS_COMP != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : {DATA_W{1'b0}};
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_HALF_DIV - 1);
   localparam logic [LW-1:0]    PRIME_LVL = LW'(PRIME_LEVEL);

   state_e            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              clk_q, clk_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [15:0]       uf_q, uf_d;
   logic              busy_q;
   logic              tick, slot, pop;
   logic              push;
   logic [DATA_W-1:0] head;
   logic              empty;

   assign push = In_Valid && In_Ready;

   da_sample_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (Sys_Clock),
      .rst_i       (Reset),
      .push_i      (push),
      .push_data_i (In_Data ^ MID),
      .pop_i       (pop),
      .head_c_o    (head),
      .empty_c_o   (empty),
      .ready_o     (In_Ready),
      .level_o     (Fifo_Level)
   );

   // Next-state, divider and sample-launch logic.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      clk_d   = clk_q;
      data_d  = data_q;
      uf_d    = uf_q;
      pop     = 1'b0;
      tick    = (div_q == DIV_LAST);
      slot    = tick && clk_q;
      case (state_q)
         IDLE: begin
            div_d  = '0;
            clk_d  = 1'b1;
            data_d = MID;
            if (Enable) begin
               state_d = PRIME;
            end
         end
         PRIME: begin
            div_d = '0;
            clk_d = 1'b1;
            if (!Enable) begin
               state_d = IDLE;
            end else if (Fifo_Level >= PRIME_LVL) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (tick) begin
               div_d = '0;
               clk_d = !clk_q;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
            // Enable is only honoured here so a DA_Clock period is never cut short.
            if (slot) begin
               if (!Enable) begin
                  data_d  = MID;
                  state_d = IDLE;
               end else if (!empty) begin
                  pop    = 1'b1;
                  data_d = head;
               end else if (uf_q != 16'hFFFF) begin
                  uf_d = uf_q + 16'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Sys_Clock) begin
      if (Reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         clk_q   <= 1'b1;
         data_q  <= MID;
         uf_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         clk_q   <= clk_d;
         data_q  <= data_d;
         uf_q    <= uf_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   assign DA_Data         = data_q;
   assign DA_Clock        = clk_q;
   assign Busy            = busy_q;
   assign Underflow_Count = uf_q;

endmodule

// File: tb/tb_da_stream_driver.sv
// Bench for da_stream_driver: queue-based model compared every cycle plus directed literal checks.
module tb_da_stream_driver;

   localparam int unsigned DW    = 14;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned CHD   = 3;
   localparam int unsigned PL    = 8;
   localparam int unsigned TC    = 1;
   localparam logic [13:0] MIDV  = 14'h2000;

   logic          Sys_Clock = 1'b0;
   logic          Reset;
   logic          Enable;
   logic [DW-1:0] In_Data;
   logic          In_Valid;
   logic          In_Ready;
   logic [DW-1:0] DA_Data;
   logic          DA_Clock;
   logic          Busy;
   logic [4:0]    Fifo_Level;
   logic [15:0]   Underflow_Count;

   always #5 Sys_Clock = ~Sys_Clock;

   da_stream_driver #(
      .DATA_W       (DW),
      .FIFO_DEPTH   (DEPTH),
      .CLK_HALF_DIV (CHD),
      .PRIME_LEVEL  (PL),
      .TWOS_COMP    (TC)
   ) dut (
      .Sys_Clock       (Sys_Clock),
      .Reset           (Reset),
      .Enable          (Enable),
      .In_Data         (In_Data),
      .In_Valid        (In_Valid),
      .In_Ready        (In_Ready),
      .DA_Data         (DA_Data),
      .DA_Clock        (DA_Clock),
      .Busy            (Busy),
      .Fifo_Level      (Fifo_Level),
      .Underflow_Count (Underflow_Count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge Sys_Clock);
   endtask

   // Offset binary is the two's complement value shifted up by half range.
   function automatic logic [13:0] conv(input logic [13:0] v);
      return (TC != 0) ? 14'(v + 14'h2000) : v;
   endfunction

   // Model: 0 = idle, 1 = priming, 2 = running; m_t counts cycles since run entry.
   logic [13:0] mq [$];
   int          m_state = 0;
   int          m_t     = 0;
   logic [13:0] m_data;
   logic        m_clk;
   logic        m_ready;
   logic        m_busy;
   logic [15:0] m_uf;
   bit          m_live  = 1'b0;

   always @(posedge Sys_Clock) begin : model
      bit do_push;
      bit had_data;
      m_live = 1'b1;
      if (Reset) begin
         mq.delete();
         m_state = 0;
         m_t     = 0;
         m_data  = MIDV;
         m_clk   = 1'b1;
         m_ready = 1'b0;
         m_busy  = 1'b0;
         m_uf    = 16'h0;
      end else begin
         do_push  = In_Valid && m_ready;
         had_data = (mq.size() > 0);
         case (m_state)
            0: begin
               m_clk  = 1'b1;
               m_data = MIDV;
               if (Enable) m_state = 1;
            end
            1: begin
               if (!Enable) m_state = 0;
               else if (mq.size() >= PL) begin
                  m_state = 2;
                  m_t     = 0;
                  m_clk   = 1'b1;
               end
            end
            default: begin
               m_t++;
               m_clk = (((m_t / CHD) % 2) == 0);
               if ((m_t % (2 * CHD)) == CHD) begin
                  if (!Enable) begin
                     m_data  = MIDV;
                     m_state = 0;
                  end else if (had_data) begin
                     m_data = mq.pop_front();
                  end else if (m_uf != 16'hFFFF) begin
                     m_uf++;
                  end
               end
            end
         endcase
         if (do_push) mq.push_back(conv(In_Data));
         m_ready = (mq.size() != DEPTH);
         m_busy  = (m_state != 0);
      end
   end

   always @(negedge Sys_Clock) begin
      if (m_live) begin
         chk("mdl DA_Data", 32'(DA_Data), 32'(m_data));
         chk("mdl DA_Clock", 32'(DA_Clock), 32'(m_clk));
         chk("mdl Busy", 32'(Busy), 32'(m_busy));
         chk("mdl In_Ready", 32'(In_Ready), 32'(m_ready));
         chk("mdl Fifo_Level", 32'(Fifo_Level), 32'(mq.size()));
         chk("mdl Underflow_Count", 32'(Underflow_Count), 32'(m_uf));
      end
   end

   logic [13:0] pv [8];

   initial begin
      pv = '{14'h0000, 14'h1FFF, 14'h2000, 14'h3FFF, 14'h0123, 14'h2ABC, 14'h1000, 14'h3000};
      Reset    = 1'b1;
      Enable   = 1'b0;
      In_Valid = 1'b0;
      In_Data  = '0;

      // Reset then idle
      cyc(2);
      chk("rst In_Ready", 32'(In_Ready), 32'd0);
      chk("rst DA_Data", 32'(DA_Data), 32'h2000);
      chk("rst DA_Clock", 32'(DA_Clock), 32'd1);
      chk("rst Busy", 32'(Busy), 32'd0);
      chk("rst Fifo_Level", 32'(Fifo_Level), 32'd0);
      chk("rst Underflow", 32'(Underflow_Count), 32'd0);
      Reset = 1'b0;
      cyc(1);
      chk("post-rst In_Ready", 32'(In_Ready), 32'd1);
      cyc(100);
      chk("idle DA_Data", 32'(DA_Data), 32'h2000);
      chk("idle DA_Clock", 32'(DA_Clock), 32'd1);
      chk("idle Busy", 32'(Busy), 32'd0);

      // Prime and stream
      Enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc(1);
         In_Valid = 1'b1;
         In_Data  = pv[i];
      end
      cyc(1);
      In_Valid = 1'b0;
      chk("prime Busy", 32'(Busy), 32'd1);
      cyc(3);
      chk("no early fall", 32'(DA_Clock), 32'd1);
      cyc(1);
      chk("first fall", 32'(DA_Clock), 32'd0);
      chk("sample0", 32'(DA_Data), 32'h2000);
      cyc(3);
      chk("rise", 32'(DA_Clock), 32'd1);
      cyc(3);
      chk("second fall", 32'(DA_Clock), 32'd0);
      chk("sample1", 32'(DA_Data), 32'h3FFF);
      cyc(6);
      chk("sample2", 32'(DA_Data), 32'h0000);
      cyc(6);
      chk("sample3", 32'(DA_Data), 32'h1FFF);

      // Underflow
      cyc(24);
      chk("sample7", 32'(DA_Data), 32'h1000);
      chk("uf before", 32'(Underflow_Count), 32'd0);
      chk("fifo drained", 32'(Fifo_Level), 32'd0);
      cyc(6);
      chk("uf 1", 32'(Underflow_Count), 32'd1);
      chk("uf hold", 32'(DA_Data), 32'h1000);
      chk("uf clk runs", 32'(DA_Clock), 32'd0);
      cyc(5);
      chk("uf still 1", 32'(Underflow_Count), 32'd1);
      cyc(1);
      chk("uf 2", 32'(Underflow_Count), 32'd2);
      cyc(1);
      Enable = 1'b0;
      cyc(5);
      chk("uf dis DA_Data", 32'(DA_Data), 32'h2000);
      chk("uf dis DA_Clock", 32'(DA_Clock), 32'd0);
      chk("uf dis count", 32'(Underflow_Count), 32'd2);
      cyc(1);
      chk("uf dis clk back", 32'(DA_Clock), 32'd1);
      chk("uf dis Busy", 32'(Busy), 32'd0);
      cyc(2);

      // Full backpressure
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (i == 15) begin
            chk("bp ready at 15", 32'(In_Ready), 32'd1);
            chk("bp level 15", 32'(Fifo_Level), 32'd15);
         end
         if (i == 16) begin
            chk("bp ready at 16", 32'(In_Ready), 32'd0);
            chk("bp level 16", 32'(Fifo_Level), 32'd16);
         end
         In_Valid = 1'b1;
         In_Data  = 14'h0100 + 14'(i);
      end
      cyc(1);
      In_Valid = 1'b0;
      chk("bp full level", 32'(Fifo_Level), 32'd16);
      chk("bp full ready", 32'(In_Ready), 32'd0);
      Enable = 1'b1;
      cyc(4);
      chk("bp pre-pop ready", 32'(In_Ready), 32'd0);
      cyc(1);
      chk("bp post-pop ready", 32'(In_Ready), 32'd1);
      chk("bp post-pop level", 32'(Fifo_Level), 32'd15);
      chk("bp first data", 32'(DA_Data), 32'h2100);

      // Disable mid-run with data queued
      cyc(1);
      Enable = 1'b0;
      cyc(5);
      chk("dis DA_Data", 32'(DA_Data), 32'h2000);
      chk("dis DA_Clock", 32'(DA_Clock), 32'd0);
      chk("dis no pop", 32'(Fifo_Level), 32'd15);
      cyc(1);
      chk("dis clk high", 32'(DA_Clock), 32'd1);
      chk("dis Busy", 32'(Busy), 32'd0);
      chk("dis level kept", 32'(Fifo_Level), 32'd15);

      // Reset mid-run with 10 samples queued
      Enable = 1'b1;
      cyc(29);
      chk("mr level 10", 32'(Fifo_Level), 32'd10);
      chk("mr data", 32'(DA_Data), 32'h2105);
      chk("mr uf", 32'(Underflow_Count), 32'd2);
      cyc(1);
      Reset = 1'b1;
      cyc(1);
      Reset = 1'b0;
      chk("mr rst level", 32'(Fifo_Level), 32'd0);
      chk("mr rst DA_Data", 32'(DA_Data), 32'h2000);
      chk("mr rst DA_Clock", 32'(DA_Clock), 32'd1);
      chk("mr rst uf", 32'(Underflow_Count), 32'd0);
      chk("mr rst Busy", 32'(Busy), 32'd0);
      chk("mr rst ready", 32'(In_Ready), 32'd0);
      Enable = 1'b0;
      cyc(1);
      chk("mr ready back", 32'(In_Ready), 32'd1);
      cyc(5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/da_stream_driver.md
Name: da_stream_driver

Overview:
- Downstream stage of the square-wave/sample generator; feeds the external 14-bit parallel DAC.
- Accepts samples over a valid/ready handshake into a small FIFO.
- Generates DA_Clock from Sys_Clock and presents one sample per DA_Clock period, launched on the DA_Clock falling edge for a half-period of setup at the DAC rising edge.
- Handles priming, underflow (hold last value, count event), enable/disable and midscale idle output.

Parameters:
- DATA_W, 14, sample and DAC width.
- FIFO_DEPTH, 16, FIFO entries; power of two, minimum 4.
- CLK_HALF_DIV, 3, Sys_Clock cycles per DA_Clock half period (108 MHz / 6 = 18 MHz); legal range 1..65535.
- PRIME_LEVEL, 8, FIFO occupancy required before output starts; legal range 1..FIFO_DEPTH.
- TWOS_COMP, 1, 1 = input is two's complement, converted to offset binary by inverting the MSB; 0 = pass through unchanged.

Ports:
- Sys_Clock  in  1  system clock (108 MHz).
- Reset  in  1  synchronous, active-high reset.
- Enable  in  1  run request.
- In_Data  in  DATA_W  input sample.
- In_Valid  in  1  In_Data valid.
- In_Ready  out  1  FIFO can accept; equals not full.
- DA_Data  out  DATA_W  DAC data, registered.
- DA_Clock  out  1  DAC clock, registered.
- Busy  out  1  high in PRIME or RUN.
- Fifo_Level  out  log2(FIFO_DEPTH)+1  current occupancy.
- Underflow_Count  out  16  saturating count of missed samples.

Behaviour:
- Interface: one clock, Sys_Clock; reset is synchronous and active-high, port Reset.
- Reset values:
  - DA_Data = midscale: 0x2000 when TWOS_COMP=1, else 0x0000.
  - DA_Clock = 1; Busy = 0; Fifo_Level = 0; Underflow_Count = 0; In_Ready = 0 during reset, 1 the cycle after.
  - FSM = IDLE; divider count = 0; FIFO pointers cleared.
  - Reset mid-operation discards all FIFO contents immediately.
- Push:
  - Occurs when In_Valid && In_Ready at a Sys_Clock edge.
  - Conversion is applied at write time.
  - Push is accepted in every state, including IDLE.
- Pop:
  - Occurs only in the update slot (defined below).
  - Simultaneous push and pop leaves Fifo_Level unchanged.
  - Push at full cannot occur because In_Ready = 0.
- Divider:
  - Active only in RUN.
  - Counts 0..CLK_HALF_DIV-1; at CLK_HALF_DIV-1 it toggles DA_Clock and wraps to 0.
  - Update slot = the cycle in which DA_Clock toggles 1->0.
- FSM:
  - IDLE: DA_Clock held 1, DA_Data held at midscale, divider at 0. Moves to PRIME when Enable = 1.
  - PRIME: waits for Fifo_Level >= PRIME_LEVEL, then moves to RUN with divider = 0 and DA_Clock = 1. If Enable = 0, returns to IDLE.
  - RUN: at each update slot:
    - FIFO non-empty: pop and register the head into DA_Data.
    - FIFO empty: hold DA_Data and increment Underflow_Count, saturating at 0xFFFF.
    - Enable = 0 sampled in an update slot: no pop; DA_Data <= midscale, DA_Clock stays 0 this cycle, next cycle DA_Clock = 1 and FSM = IDLE.
    - Enable changes outside an update slot take effect only at the next update slot, so a DA_Clock period is never truncated.
- Latency:
  - PRIME->RUN transition at edge T.
  - First DA_Clock fall and first sample on DA_Data at T + CLK_HALF_DIV.
  - Later samples every 2*CLK_HALF_DIV cycles.
- Underflow_Count clears only on Reset.
- All outputs are driven directly from flops; no combinational path from In_Valid to DA pins.

Decomposition:
- Shared package holds:
  - DATA_W.
  - MIDSCALE constant (14'h2000).
  - FSM state enum {IDLE, PRIME, RUN}.
  - Default CLK_HALF_DIV for the 108 MHz system.
- One natural sub-module: da_sample_fifo, a synchronous single-clock FIFO with push/pop/full/empty/level.
- The divider and FSM stay in the top level.

Test Plan:
- Reset then idle: Reset 2 cycles, Enable = 0 -> DA_Data = 0x2000, DA_Clock = 1, In_Ready = 1, Busy = 0, held for 100 cycles.
- Prime and stream: push 0x0000, 0x1FFF, 0x2000, 0x3FFF plus 4 more with TWOS_COMP=1, Enable = 1, CLK_HALF_DIV=3 -> RUN entered after the 8th push; DA_Data sequence 0x2000, 0x3FFF, 0x0000, 0x1FFF...; each value changes on DA_Clock fall; DA_Clock period 6 cycles; first fall exactly 3 cycles after RUN entry.
- Underflow: prime 8 samples, stop pushing -> after 8 updates DA_Data holds the last value; Underflow_Count increments by 1 every 6 cycles; DA_Clock keeps running.
- Full backpressure: Enable = 0, push 20 samples with In_Valid continuously high -> In_Ready drops after 16 accepted; Fifo_Level = 16; enable RUN -> In_Ready high again the cycle after the first pop.
- Disable mid-run: deassert Enable 1 cycle after an update slot -> next update slot does no pop; DA_Data = 0x2000, then DA_Clock = 1, FSM = IDLE; Fifo_Level unchanged.
- Reset mid-run with 10 samples queued: Reset 1 cycle -> next cycle Fifo_Level = 0, DA_Data = 0x2000, DA_Clock = 1, Underflow_Count = 0.
